// File: rtl/serv_ibus_prefetch_pkg.sv
// rtl/serv_ibus_prefetch_pkg.sv - shared types and helpers for the instruction prefetch buffer
package serv_ibus_prefetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEMAND   = 2'd1,
    ST_PREFETCH = 2'd2
  } state_e;

  // Word-address increment; wraps modulo 2^30 so 0xFFFFFFFC is followed by 0x00000000.
  function automatic logic [29:0] inc_word(input logic [29:0] a);
    return a + 30'd1;
  endfunction

endpackage

// File: rtl/serv_ibus_prefetch_if.sv
// rtl/serv_ibus_prefetch_if.sv - Wishbone-style instruction bus (adr/cyc/rdt/ack)
interface serv_ibus_prefetch_if;
  logic [31:0] adr;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, cyc, input rdt, ack);
  modport slave  (input adr, cyc, output rdt, ack);
endinterface

// File: rtl/serv_ibus_prefetch.sv
// rtl/serv_ibus_prefetch.sv - single-entry instruction prefetch buffer between core fetch and memory
module serv_ibus_prefetch
  import serv_ibus_prefetch_pkg::*;
#(
  parameter int unsigned PREFETCH_EN = 1
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  serv_ibus_prefetch_if.slave          cpu,
  serv_ibus_prefetch_if.master         mem
);

  localparam bit PF = (PREFETCH_EN != 0);

  state_e      state_q, state_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [31:0] cpu_rdt_q, cpu_rdt_d;
  logic        mem_cyc_q, mem_cyc_d;
  logic [29:0] mem_adr_q, mem_adr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [29:0] buf_adr_q, buf_adr_d;
  logic        buf_valid_q, buf_valid_d;
  logic        drop_q, drop_d;
  logic [29:0] next_adr_q, next_adr_d;

  logic [29:0] req_adr;
  logic        req;
  logic        mem_done;
  logic        hit;
  logic        unused_adr_lsb;

  // The core keeps cyc high during the cycle it sees ack; that cycle is not a new request.
  assign req_adr        = cpu.adr[31:2];
  assign req            = cpu.cyc & ~cpu_ack_q;
  assign mem_done       = mem.ack & mem_cyc_q;
  assign hit            = req & buf_valid_q & ~i_flush & (req_adr == buf_adr_q);
  assign unused_adr_lsb = ^cpu.adr[1:0];

  // Next-state and registered-output computation for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    cpu_ack_d   = 1'b0;
    cpu_rdt_d   = cpu_rdt_q;
    mem_cyc_d   = mem_cyc_q;
    mem_adr_d   = mem_adr_q;
    buf_data_d  = buf_data_q;
    buf_adr_d   = buf_adr_q;
    buf_valid_d = buf_valid_q;
    drop_d      = drop_q;
    next_adr_d  = next_adr_q;

    if (i_flush) buf_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          cpu_ack_d   = 1'b1;
          cpu_rdt_d   = buf_data_q;
          buf_valid_d = 1'b0;
          next_adr_d  = inc_word(buf_adr_q);
          mem_adr_d   = inc_word(buf_adr_q);
          if (PF) state_d = ST_PREFETCH;
        end else if (req) begin
          mem_cyc_d   = 1'b1;
          mem_adr_d   = req_adr;
          buf_valid_d = 1'b0;
          state_d     = ST_DEMAND;
        end
      end

      ST_DEMAND: begin
        if (mem_done) begin
          cpu_ack_d  = 1'b1;
          cpu_rdt_d  = mem.rdt;
          mem_cyc_d  = 1'b0;
          next_adr_d = inc_word(mem_adr_q);
          mem_adr_d  = inc_word(mem_adr_q);
          state_d    = PF ? ST_PREFETCH : ST_IDLE;
        end
      end

      ST_PREFETCH: begin
        // cyc is raised one cycle after entry so consecutive transactions stay delimited.
        mem_cyc_d = 1'b1;
        if (i_flush) drop_d = 1'b1;
        if (mem_done) begin
          if (drop_q | i_flush) begin
            drop_d    = 1'b0;
            mem_cyc_d = 1'b0;
            state_d   = ST_IDLE;
          end else if (req && (req_adr == next_adr_q)) begin
            cpu_ack_d  = 1'b1;
            cpu_rdt_d  = mem.rdt;
            mem_cyc_d  = 1'b0;
            next_adr_d = inc_word(next_adr_q);
            mem_adr_d  = inc_word(next_adr_q);
          end else if (req) begin
            mem_adr_d = req_adr;
            state_d   = ST_DEMAND;
          end else begin
            buf_data_d  = mem.rdt;
            buf_adr_d   = next_adr_q;
            buf_valid_d = 1'b1;
            mem_cyc_d   = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_cyc_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cpu_ack_q   <= 1'b0;
      cpu_rdt_q   <= 32'd0;
      mem_cyc_q   <= 1'b0;
      mem_adr_q   <= 30'd0;
      buf_data_q  <= 32'd0;
      buf_adr_q   <= 30'd0;
      buf_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      next_adr_q  <= 30'd0;
    end else begin
      state_q     <= state_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdt_q   <= cpu_rdt_d;
      mem_cyc_q   <= mem_cyc_d;
      mem_adr_q   <= mem_adr_d;
      buf_data_q  <= buf_data_d;
      buf_adr_q   <= buf_adr_d;
      buf_valid_q <= buf_valid_d;
      drop_q      <= drop_d;
      next_adr_q  <= next_adr_d;
    end
  end

  assign cpu.ack = cpu_ack_q;
  assign cpu.rdt = cpu_rdt_q;
  assign mem.cyc = mem_cyc_q;
  assign mem.adr = {mem_adr_q, 2'b00};

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// tb/tb_serv_ibus_prefetch.sv - directed self-checking bench for serv_ibus_prefetch
module tb_serv_ibus_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush0;
  logic flush1;

  serv_ibus_prefetch_if cpu0 ();
  serv_ibus_prefetch_if mem0 ();
  serv_ibus_prefetch_if cpu1 ();
  serv_ibus_prefetch_if mem1 ();

  serv_ibus_prefetch #(.PREFETCH_EN(1)) dut0 (
    .clk(clk), .i_rst(rst), .i_flush(flush0), .cpu(cpu0), .mem(mem0)
  );

  serv_ibus_prefetch #(.PREFETCH_EN(0)) dut1 (
    .clk(clk), .i_rst(rst), .i_flush(flush1), .cpu(cpu1), .mem(mem1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h0010_0113;
      default:       return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  // Memory models: ack after lat cycles of cyc, updated 2ns after posedge.
  int lat0 = 2;
  bit hold0 = 1'b0;
  int cnt0 = 0;
  int acks0 = 0;
  int cnt1 = 0;
  int acks1 = 0;

  always begin
    @(posedge clk);
    #2;
    if (mem0.ack) begin
      mem0.ack = 1'b0;
      cnt0 = 0;
    end else if (!mem0.cyc) begin
      cnt0 = 0;
    end else if (!hold0) begin
      cnt0++;
      if (cnt0 >= lat0) begin
        mem0.ack = 1'b1;
        mem0.rdt = mem_word(mem0.adr);
        acks0++;
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (mem1.ack) begin
      mem1.ack = 1'b0;
      cnt1 = 0;
    end else if (mem1.cyc) begin
      mem1.ack = 1'b1;
      mem1.rdt = mem_word(mem1.adr);
      acks1++;
    end
  end

  // Issue one fetch from a negedge and wait (bounded) for the ack.
  task automatic fetch(input bit sel, input logic [31:0] a, input bit fl,
                       output logic [31:0] data, output int lat, output logic [31:0] madr);
    bit got;
    bit seen;
    got  = 1'b0;
    seen = 1'b0;
    data = 32'd0;
    lat  = 0;
    madr = 32'hFFFF_FFFF;
    if (sel) begin
      cpu1.adr = a;
      cpu1.cyc = 1'b1;
    end else begin
      cpu0.adr = a;
      cpu0.cyc = 1'b1;
      flush0   = fl;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      flush0 = 1'b0;
      lat++;
      if (!seen && (sel ? mem1.cyc : mem0.cyc)) begin
        seen = 1'b1;
        madr = sel ? mem1.adr : mem0.adr;
      end
      if (sel ? cpu1.ack : cpu0.ack) begin
        got  = 1'b1;
        data = sel ? cpu1.rdt : cpu0.rdt;
      end
    end
    if (sel) cpu1.cyc = 1'b0;
    else     cpu0.cyc = 1'b0;
    check("ack_seen", {31'd0, got}, 32'd1);
  endtask

  logic [31:0] d;
  logic [31:0] ma;
  int l;
  int a0;
  int busy;

  initial begin
    rst = 1'b1;
    flush0 = 1'b0;
    flush1 = 1'b0;
    cpu0.cyc = 1'b0; cpu0.adr = 32'd0;
    cpu1.cyc = 1'b0; cpu1.adr = 32'd0;
    mem0.ack = 1'b0; mem0.rdt = 32'd0;
    mem1.ack = 1'b0; mem1.rdt = 32'd0;
    repeat (2) @(negedge clk);

    check("rst_cpu_ack", {31'd0, cpu0.ack}, 32'd0);
    check("rst_cpu_rdt", cpu0.rdt, 32'd0);
    check("rst_mem_cyc", {31'd0, mem0.cyc}, 32'd0);
    check("rst_mem_adr", mem0.adr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, then prefetch of the next word is issued.
    fetch(1'b0, 32'h100, 1'b0, d, l, ma);
    check("cold_rdt", d, 32'h0050_0093);
    check("cold_lat", l, 32'd3);
    hold0 = 1'b1;
    @(negedge clk);
    check("pf_cyc", {31'd0, mem0.cyc}, 32'd1);
    check("pf_adr", mem0.adr, 32'h104);

    // Reset in the middle of the prefetch.
    #1 rst = 1'b1;
    #1;
    rst = 1'b0;
    check("midrst_mem_cyc", {31'd0, mem0.cyc}, 32'd0);
    check("midrst_cpu_ack", {31'd0, cpu0.ack}, 32'd0);
    hold0 = 1'b0;
    @(negedge clk);

    fetch(1'b0, 32'h100, 1'b0, d, l, ma);
    check("postrst_madr", ma, 32'h100);
    check("postrst_rdt", d, 32'h0050_0093);
    repeat (6) @(negedge clk);
    check("fill_idle_cyc", {31'd0, mem0.cyc}, 32'd0);

    // Sequential fetch hits the buffer.
    hold0 = 1'b1;
    fetch(1'b0, 32'h104, 1'b0, d, l, ma);
    check("hit_rdt", d, 32'h0010_0113);
    check("hit_lat", l, 32'd1);
    @(negedge clk);
    check("pf2_cyc", {31'd0, mem0.cyc}, 32'd1);
    check("pf2_adr", mem0.adr, 32'h108);

    // Branch away while the prefetch is pending.
    hold0 = 1'b0;
    a0 = acks0;
    fetch(1'b0, 32'h200, 1'b0, d, l, ma);
    check("branch_rdt", d, 32'hDEAD_0200);
    check("branch_acks", acks0 - a0, 32'd2);

    // Flush during a prefetch: the matching data must be dropped.
    hold0 = 1'b1;
    @(negedge clk);
    check("pf3_adr", mem0.adr, 32'h204);
    flush0 = 1'b1;
    @(negedge clk);
    flush0 = 1'b0;
    hold0 = 1'b0;
    a0 = acks0;
    fetch(1'b0, 32'h204, 1'b0, d, l, ma);
    check("flush_rdt", d, 32'hDEAD_0204);
    check("flush_acks", acks0 - a0, 32'd2);

    // Address wrap of the prefetch.
    fetch(1'b0, 32'hFFFF_FFFC, 1'b0, d, l, ma);
    check("wrap_rdt", d, 32'h2152_FFFC);
    hold0 = 1'b1;
    @(negedge clk);
    check("wrap_cyc", {31'd0, mem0.cyc}, 32'd1);
    check("wrap_adr", mem0.adr, 32'h0);

    // Flush beats a simultaneous hit in IDLE.
    hold0 = 1'b0;
    repeat (6) @(negedge clk);
    check("wrap_fill_cyc", {31'd0, mem0.cyc}, 32'd0);
    a0 = acks0;
    fetch(1'b0, 32'h0, 1'b1, d, l, ma);
    check("flushhit_rdt", d, 32'hDEAD_0000);
    check("flushhit_acks", acks0 - a0, 32'd1);
    check("flushhit_lat", l, 32'd3);

    // Pass-through build never fetches speculatively.
    fetch(1'b1, 32'h300, 1'b0, d, l, ma);
    check("np_rdt", d, 32'hDEAD_0300);
    busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem1.cyc) busy++;
    end
    check("np_idle_cyc", busy, 32'd0);
    a0 = acks1;
    fetch(1'b1, 32'h304, 1'b0, d, l, ma);
    check("np_rdt2", d, 32'hDEAD_0304);
    check("np_acks", acks1 - a0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
